// File: rtl/iomem_arbiter.sv
// Two-port arbiter/sequencer for the shared 128-bit iomem block-RAM port.
// Optional round-robin arbitration: define IOMEM_ARB_ROUND_ROBIN_EN (default is fixed priority, port 0 wins).
module iomem_arbiter #(
  parameter int          BLOCK_SIZE    = 128,
  parameter int          NUMS_BYTE     = BLOCK_SIZE / 8,
  parameter int          RAM_DELAY     = 16,
  parameter logic [31:0] RAM_BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] RAM_MASK_ADDR = 32'h000f_ffff
) (
  input  logic                  clk_o,
  input  logic                  rst_n,

  input  logic                  m0_valid_i,
  input  logic [31:0]           m0_addr_i,
  input  logic [NUMS_BYTE-1:0]  m0_wstrb_i,
  input  logic [BLOCK_SIZE-1:0] m0_wdata_i,
  output logic                  m0_ready_o,
  output logic [BLOCK_SIZE-1:0] m0_rdata_o,

  input  logic                  m1_valid_i,
  input  logic [31:0]           m1_addr_i,
  input  logic [NUMS_BYTE-1:0]  m1_wstrb_i,
  input  logic [BLOCK_SIZE-1:0] m1_wdata_i,
  output logic                  m1_ready_o,
  output logic [BLOCK_SIZE-1:0] m1_rdata_o,

  output logic [31:0]           mem_addr_o,
  output logic [BLOCK_SIZE-1:0] mem_wdata_o,
  output logic [NUMS_BYTE-1:0]  mem_wstrb_o,
  output logic                  mem_rd_en_o,
  input  logic [BLOCK_SIZE-1:0] mem_rdata_i,

  output logic                  owner_o,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(RAM_DELAY - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_cnt;
  logic [BLOCK_SIZE-1:0] r_rdata;
  logic [31:0]           r_addr;
  logic [NUMS_BYTE-1:0]  r_wstrb;
  logic [BLOCK_SIZE-1:0] r_wdata;
  logic                  r_owner;
  logic                  r_err;

  logic                  w_any;
  logic                  w_sel;
  logic [31:0]           w_req_addr;
  logic [NUMS_BYTE-1:0]  w_req_wstrb;
  logic [BLOCK_SIZE-1:0] w_req_wdata;
  logic                  w_in_win;
  logic                  w_is_read;

`ifdef IOMEM_ARB_ROUND_ROBIN_EN
  logic                  r_last;
`endif

  // Winner selection; a lone valid always wins regardless of policy.
  always_comb begin
    w_any = m0_valid_i | m1_valid_i;
`ifdef IOMEM_ARB_ROUND_ROBIN_EN
    w_sel = (m0_valid_i && m1_valid_i) ? ~r_last : ~m0_valid_i;
`else
    w_sel = ~m0_valid_i;
`endif
    w_req_addr  = w_sel ? m1_addr_i  : m0_addr_i;
    w_req_wstrb = w_sel ? m1_wstrb_i : m0_wstrb_i;
    w_req_wdata = w_sel ? m1_wdata_i : m0_wdata_i;
    w_in_win    = (w_req_addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR;
    w_is_read   = (r_wstrb == '0);
  end

  always_ff @(posedge clk_o) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_rd_en_o = 1'b0;
    mem_wstrb_o = '0;
    m0_ready_o  = 1'b0;
    m1_ready_o  = 1'b0;
    err_o       = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (w_any) w_state_nxt = w_in_win ? S_ISSUE : S_RESP;
      end
      S_ISSUE: begin
        mem_rd_en_o = w_is_read;
        mem_wstrb_o = r_wstrb;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        m0_ready_o  = ~r_owner;
        m1_ready_o  = r_owner;
        err_o       = r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_o) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_owner <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_sel;
            r_addr  <= w_req_addr;
            r_wstrb <= w_req_wstrb;
            r_wdata <= w_req_wdata;
            r_err   <= ~w_in_win;
            // Out-of-window reads return zero data; out-of-window writes keep it.
            if (!w_in_win && w_req_wstrb == '0) r_rdata <= '0;
          end
        end
        S_ISSUE: r_cnt <= CNT_LOAD;
        S_WAIT: begin
          if (r_cnt == '0) begin
            if (w_is_read) r_rdata <= mem_rdata_i;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IOMEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_o) begin
    if (!rst_n)                r_last <= 1'b1;
    else if (r_state == S_RESP) r_last <= r_owner;
  end
`endif

  assign m0_rdata_o  = r_rdata;
  assign m1_rdata_o  = r_rdata;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign owner_o     = r_owner;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Randomized self-checking bench for iomem_arbiter against a transaction-level model.
// Honors IOMEM_ARB_ROUND_ROBIN_EN when defined for the whole build.
module tb_iomem_arbiter;

  localparam int          RAM_DELAY = 16;
  localparam logic [31:0] BASE      = 32'h4000_0000;
  localparam logic [31:0] MASK      = 32'h000f_ffff;

  logic         clk_o = 1'b0;
  logic         rst_n;
  logic         m0_valid_i, m1_valid_i;
  logic [31:0]  m0_addr_i, m1_addr_i;
  logic [15:0]  m0_wstrb_i, m1_wstrb_i;
  logic [127:0] m0_wdata_i, m1_wdata_i;
  logic         m0_ready_o, m1_ready_o;
  logic [127:0] m0_rdata_o, m1_rdata_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [15:0]  mem_wstrb_o;
  logic         mem_rd_en_o;
  logic [127:0] mem_rdata_i;
  logic         owner_o, busy_o, err_o;

  int unsigned  cyc = 0;
  int unsigned  checks = 0;
  int unsigned  errors = 0;
  bit           m_last;
  logic [127:0] m_rdata;

  iomem_arbiter #(
    .BLOCK_SIZE(128),
    .RAM_DELAY (RAM_DELAY)
  ) dut (
    .clk_o      (clk_o),
    .rst_n      (rst_n),
    .m0_valid_i (m0_valid_i),
    .m0_addr_i  (m0_addr_i),
    .m0_wstrb_i (m0_wstrb_i),
    .m0_wdata_i (m0_wdata_i),
    .m0_ready_o (m0_ready_o),
    .m0_rdata_o (m0_rdata_o),
    .m1_valid_i (m1_valid_i),
    .m1_addr_i  (m1_addr_i),
    .m1_wstrb_i (m1_wstrb_i),
    .m1_wdata_i (m1_wdata_i),
    .m1_ready_o (m1_ready_o),
    .m1_rdata_o (m1_rdata_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o),
    .mem_rd_en_o(mem_rd_en_o),
    .mem_rdata_i(mem_rdata_i),
    .owner_o    (owner_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk_o = ~clk_o;
  always @(posedge clk_o) cyc <= cyc + 1;

  // RAM returns a distinct pattern every cycle so capture timing is observable.
  function automatic logic [127:0] ram_pat(input int unsigned c);
    return {c * 32'h9E37_79B9, c ^ 32'hA5A5_0F0F, ~c, c + 32'h1357_9BDF};
  endfunction

  assign mem_rdata_i = ram_pat(cyc);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_rdy0"}, m0_ready_o, 1'b0);
    chk({tag, "_rdy1"}, m1_ready_o, 1'b0);
    chk({tag, "_err"}, err_o, 1'b0);
    chk({tag, "_rden"}, mem_rd_en_o, 1'b0);
    chk({tag, "_wstrb"}, mem_wstrb_o, 16'h0);
  endtask

  // Called just after a negedge in an IDLE cycle; returns after the following IDLE cycle's negedge.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [15:0] s0, input logic [15:0] s1,
                         input logic [127:0] d0, input logic [127:0] d1,
                         input int drop_at, input bit hold);
    bit           w;
    logic [31:0]  aw;
    logic [15:0]  sw;
    logic [127:0] dw;
    bit           inw, rd;
    int           lat;
    int unsigned  c0;
    m0_valid_i = v0; m0_addr_i = a0; m0_wstrb_i = s0; m0_wdata_i = d0;
    m1_valid_i = v1; m1_addr_i = a1; m1_wstrb_i = s1; m1_wdata_i = d1;
`ifdef IOMEM_ARB_ROUND_ROBIN_EN
    w = (v0 && v1) ? !m_last : !v0;
`else
    w = !v0;
`endif
    aw  = w ? a1 : a0;
    sw  = w ? s1 : s0;
    dw  = w ? d1 : d0;
    inw = (aw & ~MASK) == BASE;
    rd  = (sw == 16'h0);
    lat = inw ? RAM_DELAY + 2 : 1;
    c0  = cyc;
    if (rd) m_rdata = inw ? ram_pat(c0 + RAM_DELAY + 1) : 128'h0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk_o);
      chk("busy", busy_o, 1'b1);
      chk("owner", owner_o, w);
      chk("rden", mem_rd_en_o, inw && rd && k == 1);
      chk("wstrb", mem_wstrb_o, (inw && k == 1) ? sw : 16'h0);
      chk("rdy0", m0_ready_o, k == lat && !w);
      chk("rdy1", m1_ready_o, k == lat && w);
      chk("err", err_o, !inw && k == lat);
      if (k == 1) begin
        chk("addr", mem_addr_o, aw);
        chk("wdata", mem_wdata_o, dw);
      end
      if (k == lat) begin
        chk("rdata0", m0_rdata_o, m_rdata);
        chk("rdata1", m1_rdata_o, m_rdata);
      end
      if (k == drop_at) begin
        m0_valid_i = 1'b0;
        m1_valid_i = 1'b0;
      end
    end
    m_last = w;
    if (!hold) begin
      m0_valid_i = 1'b0;
      m1_valid_i = 1'b0;
    end
    @(negedge clk_o);
    chk_idle("gap");
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 5) == 0) return $urandom;
    return BASE | ($urandom & MASK);
  endfunction

  function automatic logic [15:0] rnd_strb();
    if ($urandom_range(0, 1) == 0) return 16'h0;
    return 16'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0;
    m0_valid_i = 1'b0; m0_addr_i = '0; m0_wstrb_i = '0; m0_wdata_i = '0;
    m1_valid_i = 1'b0; m1_addr_i = '0; m1_wstrb_i = '0; m1_wdata_i = '0;
    m_last = 1'b1;
    m_rdata = '0;
    repeat (3) @(negedge clk_o);
    chk_idle("rst");
    chk("rst_rdata0", m0_rdata_o, 128'h0);
    chk("rst_rdata1", m1_rdata_o, 128'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_wdata", mem_wdata_o, 128'h0);
    chk("rst_owner", owner_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk_o);
    chk_idle("post_rst");

    run_txn(1, 0, 32'h4000_0010, 32'h0, 16'h0, 16'h0, rnd128(), rnd128(), 0, 0);
    run_txn(0, 1, 32'h0, 32'h4000_0020, 16'h0, 16'h00FF, rnd128(), rnd128(), 0, 0);
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, BASE | 32'h100, BASE | 32'h200, 16'h0, 16'hF000, rnd128(), rnd128(), 0, 1);
    run_txn(1, 0, 32'h3000_0000, 32'h0, 16'h0, 16'h0, rnd128(), rnd128(), 0, 0);

    // Reset in the middle of a port 1 read.
    m1_valid_i = 1'b1; m1_addr_i = BASE | 32'h40; m1_wstrb_i = 16'h0;
    repeat (6) @(negedge clk_o);
    chk("rst_wait_busy", busy_o, 1'b1);
    rst_n = 1'b0;
    m1_valid_i = 1'b0;
    @(negedge clk_o);
    chk_idle("rst_wait");
    chk("rst_wait_rdata", m0_rdata_o, 128'h0);
    chk("rst_wait_owner", owner_o, 1'b0);
    rst_n = 1'b1;
    m_last = 1'b1;
    m_rdata = '0;
    repeat (RAM_DELAY + 4) begin
      @(negedge clk_o);
      chk_idle("rst_quiet");
    end
    run_txn(1, 1, BASE | 32'h300, BASE | 32'h400, 16'h0, 16'h0, rnd128(), rnd128(), 0, 0);

    run_txn(1, 0, BASE | 32'h500, 32'h0, 16'h0, 16'h0, rnd128(), rnd128(), 5, 0);

    for (int i = 0; i < 40; i++) begin
      int unsigned pat;
      pat = $urandom_range(1, 3);
      run_txn(pat[0], pat[1], rnd_addr(), rnd_addr(), rnd_strb(), rnd_strb(),
              rnd128(), rnd128(),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : 0,
              $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        m0_valid_i = 1'b0;
        m1_valid_i = 1'b0;
        repeat ($urandom_range(1, 2)) begin
          @(negedge clk_o);
          chk_idle("rnd_gap");
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
